// File: rtl/fx_pkg.sv
// Shared constants for the multichannel distortion engine.
// Contents: Avalon word addresses, STATUS bit positions, a unity-gain helper.
// Used by fx_multichannel_distortion.
package fx_pkg;

    localparam logic [4:0] ADDR_STATUS    = 5'h00;
    localparam logic [4:0] ADDR_CTRL      = 5'h01;
    localparam logic [4:0] ADDR_INPUT     = 5'h02;
    localparam logic [4:0] ADDR_OUTPUT    = 5'h03;
    localparam logic [4:0] ADDR_LEVEL     = 5'h04;
    localparam logic [4:0] ADDR_CH_BASE   = 5'h08;
    localparam logic [4:0] ADDR_CLIP_BASE = 5'h18;

    localparam int ST_IN_EMPTY  = 0;
    localparam int ST_IN_FULL   = 1;
    localparam int ST_OUT_EMPTY = 2;
    localparam int ST_OUT_FULL  = 3;
    localparam int ST_OVERFLOW  = 4;
    localparam int ST_UNDERFLOW = 5;

    // Fixed-point 1.0 for a gain with 'frac' fraction bits.
    function automatic logic [31:0] unity_gain(input int frac);
        return 32'd1 << frac;
    endfunction

endpackage

// File: rtl/fx_sync_fifo.sv
// Single-clock FIFO with show-ahead output (q is the head entry whenever !empty).
// Ports: clk_500, reset (sync, active-high), push/din, pop, q, full, empty, level.
// Push while full and pop while empty are ignored; simultaneous push/pop keeps level.
module fx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_500,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       q,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_500) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_500) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign q     = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/fx_multichannel_distortion.sv
// Avalon-MM multichannel distortion engine. Host pushes tagged samples into an
// input FIFO; a 3-stage pipeline (pop / gain multiply / symmetric clip) moves
// them to an output FIFO that the host drains through the OUTPUT register.
// Ports: clk_500, reset (sync, active-high), avl_address/read/write/writedata,
//        avl_readdata/readdatavalid (1-cycle read latency), irq (level).
// Build option: define CLIP_COUNT_EN for per-channel saturating clip counters
// at 0x18+ch; otherwise those addresses read 0 and ignore writes.
module fx_multichannel_distortion
    import fx_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 8,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int IRQ_LEVEL = 8
) (
    input  logic        clk_500,
    input  logic        reset,
    input  logic [4:0]  avl_address,
    input  logic        avl_read,
    input  logic        avl_write,
    input  logic [31:0] avl_writedata,
    output logic [31:0] avl_readdata,
    output logic        avl_readdatavalid,
    output logic        irq
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CHW1   = CH_W + 1;
    localparam int FW     = DATA_W + CH_W;
    localparam int PW     = DATA_W + GAIN_W + 1;
    localparam int IN_LW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_LW = $clog2(OUT_DEPTH) + 1;
    localparam int SW     = OUT_LW + 1;
    localparam logic [DATA_W-1:0] THR_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(unity_gain(GAIN_FRAC));

    // register file
    logic              ctrl_enable;
    logic              ctrl_irq_en;
    logic [NUM_CH-1:0] ctrl_bypass;
    logic [GAIN_W-1:0] gain_q   [NUM_CH];
    logic [DATA_W-1:0] thresh_q [NUM_CH];
    logic              sticky_ovf;
    logic              sticky_unf;

    // FIFO interfaces
    logic              in_push, in_pop, in_full, in_empty;
    logic [FW-1:0]     in_q;
    logic [IN_LW-1:0]  in_level;
    logic              out_push, out_pop, out_full, out_empty;
    logic [FW-1:0]     out_din, out_q;
    logic [OUT_LW-1:0] out_level;

    // bus decode
    logic              rd_only;
    logic [4:0]        ch_off;
    logic              ch_hit;
    logic [CH_W-1:0]   ch_sel;
    logic              ovf_set, unf_set;
    logic              status_wr;
    logic [31:0]       rd_mux;
    logic              unused_wd;

    // pipeline
    logic                     s1_valid;
    logic [CH_W-1:0]          s1_ch;
    logic [DATA_W-1:0]        s1_sample;
    logic [CH_W-1:0]          p1_ch;
    logic signed [PW-1:0]     mul_a, mul_b, prod, p1_val;
    logic [DATA_W-1:0]        p1_thr;
    logic                     s2_valid;
    logic [CH_W-1:0]          s2_ch;
    logic signed [PW-1:0]     s2_val;
    logic [DATA_W-1:0]        s2_thr;
    logic                     s2_bypass;
    logic signed [PW-1:0]     thr_pos, thr_neg;
    logic                     clip_hi, clip_lo;
    logic [DATA_W-1:0]        out_sample;
    logic [1:0]               inflight;

    assign unused_wd = ^avl_writedata;

    assign rd_only = avl_read && !avl_write;
    assign ch_off  = avl_address - ADDR_CH_BASE;
    assign ch_hit  = (avl_address >= ADDR_CH_BASE) && (ch_off < 5'(2*NUM_CH));
    assign ch_sel  = ch_off[CH_W:1];

    assign in_push   = avl_write && (avl_address == ADDR_INPUT) && !in_full;
    assign ovf_set   = avl_write && (avl_address == ADDR_INPUT) && in_full;
    assign out_pop   = rd_only && (avl_address == ADDR_OUTPUT) && !out_empty;
    assign unf_set   = rd_only && (avl_address == ADDR_OUTPUT) && out_empty;
    assign status_wr = avl_write && (avl_address == ADDR_STATUS);

    fx_sync_fifo #(.WIDTH(FW), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk_500 (clk_500),
        .reset   (reset),
        .push    (in_push),
        .din     (avl_writedata[FW-1:0]),
        .pop     (in_pop),
        .q       (in_q),
        .full    (in_full),
        .empty   (in_empty),
        .level   (in_level)
    );

    fx_sync_fifo #(.WIDTH(FW), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk_500 (clk_500),
        .reset   (reset),
        .push    (out_push),
        .din     (out_din),
        .pop     (out_pop),
        .q       (out_q),
        .full    (out_full),
        .empty   (out_empty),
        .level   (out_level)
    );

    always_ff @(posedge clk_500) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_bypass <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                gain_q[i]   <= GAIN_ONE;
                thresh_q[i] <= THR_MAX;
            end
        end else if (avl_write) begin
            if (avl_address == ADDR_CTRL) begin
                ctrl_enable <= avl_writedata[0];
                ctrl_irq_en <= avl_writedata[1];
                ctrl_bypass <= avl_writedata[8 +: NUM_CH];
            end else if (ch_hit) begin
                if (!ch_off[0]) gain_q[ch_sel]   <= avl_writedata[GAIN_W-1:0];
                else            thresh_q[ch_sel] <= avl_writedata[DATA_W-1:0];
            end
        end
    end

    // Sticky set takes priority over a same-cycle write-one-to-clear.
    always_ff @(posedge clk_500) begin
        if (reset) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            if (ovf_set)
                sticky_ovf <= 1'b1;
            else if (status_wr && avl_writedata[ST_OVERFLOW])
                sticky_ovf <= 1'b0;
            if (unf_set)
                sticky_unf <= 1'b1;
            else if (status_wr && avl_writedata[ST_UNDERFLOW])
                sticky_unf <= 1'b0;
        end
    end

    // P0: only pop when the output FIFO is guaranteed room for everything in flight.
    assign inflight = {1'b0, s1_valid} + {1'b0, s2_valid};
    assign in_pop   = ctrl_enable && !in_empty &&
                      ((SW'(out_level) + SW'(inflight)) < SW'(OUT_DEPTH));

    always_ff @(posedge clk_500) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_sample <= '0;
        end else begin
            s1_valid  <= in_pop;
            s1_ch     <= in_q[FW-1:DATA_W];
            s1_sample <= in_q[DATA_W-1:0];
        end
    end

    // P1: tags beyond NUM_CH use channel 0 settings and leave tagged as 0.
    assign p1_ch  = ({1'b0, s1_ch} < CHW1'(NUM_CH)) ? s1_ch : '0;
    assign mul_a  = PW'($signed(s1_sample));
    assign mul_b  = $signed(PW'(gain_q[p1_ch]));
    assign prod   = mul_a * mul_b;
    assign p1_val = ctrl_bypass[p1_ch] ? mul_a : (prod >>> GAIN_FRAC);
    assign p1_thr = (thresh_q[p1_ch] > THR_MAX) ? THR_MAX : thresh_q[p1_ch];

    always_ff @(posedge clk_500) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_ch     <= '0;
            s2_val    <= '0;
            s2_thr    <= '0;
            s2_bypass <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_ch     <= p1_ch;
            s2_val    <= p1_val;
            s2_thr    <= p1_thr;
            s2_bypass <= ctrl_bypass[p1_ch];
        end
    end

    // P2: symmetric clip, then push.
    assign thr_pos = $signed(PW'(s2_thr));
    assign thr_neg = -thr_pos;
    assign clip_hi = !s2_bypass && (s2_val > thr_pos);
    assign clip_lo = !s2_bypass && (s2_val < thr_neg);

    always_comb begin
        out_sample = s2_val[DATA_W-1:0];
        if (clip_hi)      out_sample = thr_pos[DATA_W-1:0];
        else if (clip_lo) out_sample = thr_neg[DATA_W-1:0];
    end

    assign out_push = s2_valid;
    assign out_din  = {s2_ch, out_sample};

`ifdef CLIP_COUNT_EN
    logic [4:0]      clip_off;
    logic            clip_hit;
    logic [CH_W-1:0] clip_sel;
    logic            clip_event;
    logic [15:0]     clip_cnt [NUM_CH];

    assign clip_off   = avl_address - ADDR_CLIP_BASE;
    assign clip_hit   = (avl_address >= ADDR_CLIP_BASE) && (clip_off < 5'(NUM_CH));
    assign clip_sel   = clip_off[CH_W-1:0];
    assign clip_event = s2_valid && (clip_hi || clip_lo);

    // A clearing write wins over a same-cycle increment.
    always_ff @(posedge clk_500) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) clip_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (avl_write && clip_hit && (clip_sel == CH_W'(i)))
                    clip_cnt[i] <= '0;
                else if (clip_event && (s2_ch == CH_W'(i)) && (clip_cnt[i] != 16'hFFFF))
                    clip_cnt[i] <= clip_cnt[i] + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (avl_address)
            ADDR_STATUS: begin
                rd_mux[ST_IN_EMPTY]  = in_empty;
                rd_mux[ST_IN_FULL]   = in_full;
                rd_mux[ST_OUT_EMPTY] = out_empty;
                rd_mux[ST_OUT_FULL]  = out_full;
                rd_mux[ST_OVERFLOW]  = sticky_ovf;
                rd_mux[ST_UNDERFLOW] = sticky_unf;
            end
            ADDR_CTRL: begin
                rd_mux[0]          = ctrl_enable;
                rd_mux[1]          = ctrl_irq_en;
                rd_mux[8 +: NUM_CH] = ctrl_bypass;
            end
            ADDR_OUTPUT: begin
                if (!out_empty)
                    rd_mux = {8'(out_q[FW-1:DATA_W]), 24'($signed(out_q[DATA_W-1:0]))};
            end
            ADDR_LEVEL: begin
                rd_mux = {16'(out_level), 16'(in_level)};
            end
            default: begin
                if (ch_hit) begin
                    if (!ch_off[0]) rd_mux = 32'(gain_q[ch_sel]);
                    else            rd_mux = 32'(thresh_q[ch_sel]);
                end
`ifdef CLIP_COUNT_EN
                else if (clip_hit) begin
                    rd_mux = 32'(clip_cnt[clip_sel]);
                end
`endif
            end
        endcase
    end

    // A read that collides with a write still completes, but returns 0.
    always_ff @(posedge clk_500) begin
        if (reset) begin
            avl_readdata      <= '0;
            avl_readdatavalid <= 1'b0;
        end else begin
            avl_readdatavalid <= avl_read;
            avl_readdata      <= rd_only ? rd_mux : 32'd0;
        end
    end

    assign irq = ctrl_irq_en && (out_level >= OUT_LW'(IRQ_LEVEL));

endmodule
